// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder with carry-in and carry-out; the only adder in the datapath.
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, cin};

endmodule : nibble_adder

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one 4-bit digit per cycle, IDLE/RUN/DONE controller.
// Define SERIAL_ADD_CTRL_SUB_EN to add the 'sub' port and subtraction (a + ~b + 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset_,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      c_in,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic                      sub,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      c_out
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NIBBLES - 1);

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                carry_q;
  logic [W-1:0]        sum_q;
  logic                c_out_q;
  logic                busy_q;
  logic                done_q;

  logic [W-1:0]        b_load;
  logic                cin_load;
  logic [NIBBLE_W-1:0] nib_x;
  logic [NIBBLE_W-1:0] nib_y;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  // Operand conditioning at acceptance: subtraction latches ~b with a forced carry of 1.
  always_comb begin
`ifdef SERIAL_ADD_CTRL_SUB_EN
    if (sub) begin
      b_load   = ~b;
      cin_load = 1'b1;
    end else begin
      b_load   = b;
      cin_load = c_in;
    end
`else
    b_load   = b;
    cin_load = c_in;
`endif
  end

  assign nib_x = a_q[{k_q, 2'b00} +: NIBBLE_W];
  assign nib_y = b_q[{k_q, 2'b00} +: NIBBLE_W];

  nibble_adder u_nibble_adder (
    .x    (nib_x),
    .y    (nib_y),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_co)
  );

  // Controller and datapath registers; k saturates at LAST_K so it never wraps.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= cin_load;
            sum_q   <= '0;
            k_q     <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[{k_q, 2'b00} +: NIBBLE_W] <= nib_s;
          carry_q <= nib_co;
          if (k_q == LAST_K) begin
            c_out_q <= nib_co;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q     <= k_q + KW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed scoreboard bench for serial_add_ctrl (NIBBLES=4); sub cases need SERIAL_ADD_CTRL_SUB_EN.
module tb_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clock = 1'b0;
  logic         reset_;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic         sub;
`endif

  int           n_assert = 0;
  int           n_fail   = 0;
  int           edge_cnt = 0;
  int           busy_cnt = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   last_exp;

  serial_add_ctrl #(.NIBBLES(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .start  (start),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .c_out  (c_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
    edge_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
    logic [W-1:0] beff;
    logic         ceff;
    beff = ts ? ~tb_ : tb_;
    ceff = ts ? 1'b1 : tc;
    a     = ta;
    b     = tb_;
    c_in  = tc;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub   = ts;
`endif
    start = 1'b1;
    exp_q.push_back({1'b0, ta} + {1'b0, beff} + {{W{1'b0}}, ceff});
    edge_cnt = 0;
    busy_cnt = 0;
    tick();
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("done_after_accept", {31'd0, done}, 32'd0);
  endtask

  // Latency is counted including the accepting edge: NIBBLES+1 edges in total.
  task automatic wait_done(input string tag);
    while (done !== 1'b1 && edge_cnt < 20) tick();
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, edge_cnt, N + 1);
    check({tag, "_busy_cycles"}, busy_cnt, N);
    check({tag, "_queue_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
    last_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, last_exp[W-1:0]});
    check({tag, "_c_out"}, {31'd0, c_out}, {31'd0, last_exp[W]});
  endtask

  task automatic release_op(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_sum_held"}, {16'd0, sum}, {16'd0, last_exp[W-1:0]});
    check({tag, "_c_out_held"}, {31'd0, c_out}, {31'd0, last_exp[W]});
  endtask

  initial begin
    reset_ = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    c_in   = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub    = 1'b0;
`endif
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_c_out", {31'd0, c_out}, 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    tick();

    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done("basic");
    release_op("basic");

    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("ripple");
    release_op("ripple");

    // Back-to-back: start held in DONE is accepted on that same edge.
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_done("allones");
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done("b2b");
    release_op("b2b");

    // A start pulse during RUN with new operands must be ignored.
    start_op(16'h1234, 16'h0F0F, 1'b0, 1'b0);
    tick();
    a     = 16'hAAAA;
    b     = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore");
    release_op("ignore");
    tick();
    check("ignore_no_extra_done", {31'd0, done}, 32'd0);
    check("ignore_stays_idle", {31'd0, busy}, 32'd0);

    // Reset on the second RUN cycle aborts without a done pulse.
    start_op(16'h00AA, 16'h0011, 1'b0, 1'b0);
    tick();
    reset_ = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {16'd0, sum}, 32'd0);
    check("abort_c_out", {31'd0, c_out}, 32'd0);
    tick();
    reset_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    start_op(16'h0010, 16'h0020, 1'b0, 1'b0);
    wait_done("after_abort");
    release_op("after_abort");

`ifdef SERIAL_ADD_CTRL_SUB_EN
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done("sub_borrow");
    check("sub_borrow_sum_lit", {16'd0, sum}, 32'h0000_FFFE);
    check("sub_borrow_c_lit", {31'd0, c_out}, 32'd0);
    release_op("sub_borrow");
    start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_done("sub_noborrow");
    check("sub_noborrow_sum_lit", {16'd0, sum}, 32'h0000_0002);
    check("sub_noborrow_c_lit", {31'd0, c_out}, 32'd1);
    release_op("sub_noborrow");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_serial_add_ctrl
